scaler_step_ctrl: RTL and testbench
===================================

Name: scaler_step_ctrl

Overview:
Configuration sequencer for the horizontal cubic scaler datapath.
- Accepts input/output line widths over a valid/ready handshake.
- Computes the fixed-point scale_step = in_width*PIXEL_STEP/out_width with an iterative divider.
- Applies the new step only at the next frame start, so a frame never mixes two scale factors.
- Sits between the register/host interface and the scale_step input of the horizontal scaler, sharing its video sync inputs.

Parameters:
- PIXEL_STEP, 4096: fixed-point 1.0; power of two; LOG2_STEP = clog2(PIXEL_STEP).
- WIDTH_BITS, 13: width of the in_width/out_width config fields.
- STEP_WIDTH, 16: width of scale_step; must match the scaler's scale_step port.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  block can accept config.
- cfg_in_width  in  WIDTH_BITS  source pixels per line.
- cfg_out_width  in  WIDTH_BITS  destination pixels per line.
- de_i  in  1  video data enable (same stream as the scaler input).
- vs_i  in  1  frame-start flag, qualified by de_i.
- scale_step  out  STEP_WIDTH  to the scaler; unsigned fixed point, PIXEL_STEP = 1.0.
- step_upd  out  1  one-cycle pulse when scale_step changes.
- busy  out  1  division in progress or result pending.
- err  out  1  last accepted config was invalid or saturated.

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - State IDLE.
  - scale_step = PIXEL_STEP.
  - step_upd = 0, busy = 0, err = 0.
  - cfg_ready = 1 after reset.
  - Pending result discarded.
  - Reset mid-DIV or mid-WAIT_SOF aborts with no step change.
- SOF event: de_i && vs_i sampled at a clk edge.
- Accept: cfg_valid && cfg_ready at a clk edge; latches both widths and clears err.
- cfg_ready = 1 in IDLE and WAIT_SOF; 0 in DIV.
- busy = 1 in DIV and WAIT_SOF.
- States:
  - IDLE: on accept, go to DIV. SOF is ignored.
  - DIV: restoring divider producing one quotient bit per cycle, MSB first.
    - Numerator = in_width << LOG2_STEP, width N = WIDTH_BITS + LOG2_STEP (25 for defaults); exactly N cycles in DIV.
    - Result is truncated.
    - If quotient > 2^STEP_WIDTH-1, pending = 2^STEP_WIDTH-1 and err = 1.
    - If quotient = 0, pending = 1 and err = 1.
    - Then go to WAIT_SOF.
    - SOF during DIV is ignored; scale_step keeps its old value and the new value waits for the following SOF.
  - out_width = 0 on accept: skip DIV, err = 1, return to IDLE, no pending value, scale_step unchanged.
  - WAIT_SOF: on SOF, scale_step <= pending (same edge), step_upd = 1 for the next cycle, go to IDLE.
    - Accept without SOF in WAIT_SOF: discard pending, restart DIV with the new widths.
    - SOF and accept on the same edge: apply the old pending value (step_upd pulses) and start DIV on the new config.
- Latency: accept at edge 0 → pending valid at edge N → applied at the first SOF edge ≥ N+1.
- scale_step is registered and changes only on a SOF edge; never glitches mid-frame.

Optional Feature:
- Macro: SCALER_STEP_CTRL_ROUND_EN.
- Defined: numerator = (in_width << LOG2_STEP) + (out_width >> 1), giving round-to-nearest. The numerator is widened by one bit and DIV lasts N+1 cycles.
- Undefined: truncation, N cycles in DIV.
- Saturation and error rules are identical in both builds.

Test Plan:
- Reset, no config: scale_step=4096, cfg_ready=1, busy=0, err=0; SOF pulses produce no step_upd.
- Config 1920→1280, then SOF after 30 cycles: busy for 25 cycles plus the wait, scale_step=6144 one edge after SOF, step_upd single pulse.
- Config 1280→1920: scale_step=2730; with SCALER_STEP_CTRL_ROUND_EN, 2731 and DIV takes 26 cycles.
- Config 8191→1: err=1, scale_step=65535 after SOF. Config 100→0: err=1 immediately, no DIV, scale_step unchanged, no step_upd.
- Configs:
  - 1920→1280 accepted; SOF at cycle 10 (mid-DIV): no change.
  - Second SOF after DIV: 6144.
  - Then 1280→640 and 640→1280 accepted back-to-back in WAIT_SOF: only 2048 applied at the next SOF.
- rst_n low for 1 cycle during DIV: state IDLE, scale_step=4096, the next SOF gives no step_upd. SOF coincident with accept in WAIT_SOF: old pending applied and the new DIV starts.

Source files
------------

// File: rtl/scaler_step_ctrl.sv
// Horizontal scaler step sequencer: scale_step = in_width*PIXEL_STEP/out_width via a
// restoring divider, applied only at frame start. Option macro: SCALER_STEP_CTRL_ROUND_EN.
module scaler_step_ctrl #(
  parameter int PIXEL_STEP = 4096,
  parameter int WIDTH_BITS = 13,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH_BITS-1:0] cfg_in_width,
  input  logic [WIDTH_BITS-1:0] cfg_out_width,
  input  logic                  de_i,
  input  logic                  vs_i,
  output logic [STEP_WIDTH-1:0] scale_step,
  output logic                  step_upd,
  output logic                  busy,
  output logic                  err
);
  // state    | meaning
  // IDLE     | nothing pending; accepts config, ignores SOF
  // DIV      | one quotient bit per cycle, MSB first
  // WAIT_SOF | result pending until the next frame start

  localparam int LOG2_STEP = $clog2(PIXEL_STEP);
`ifdef SCALER_STEP_CTRL_ROUND_EN
  localparam int NUM_W = WIDTH_BITS + LOG2_STEP + 1;
`else
  localparam int NUM_W = WIDTH_BITS + LOG2_STEP;
`endif
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [STEP_WIDTH-1:0] STEP_RST = STEP_WIDTH'(PIXEL_STEP);

  typedef enum logic [1:0] {IDLE, DIV, WAIT_SOF} state_e;

  state_e                  state_q;
  logic [NUM_W-1:0]        num_q;
  logic [NUM_W-1:0]        quo_q;
  logic [WIDTH_BITS-1:0]   rem_q;
  logic [WIDTH_BITS-1:0]   out_w_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [STEP_WIDTH-1:0]   pend_q;
  logic [STEP_WIDTH-1:0]   step_q;
  logic                    upd_q;
  logic                    err_q;

  logic                    accept;
  logic                    sof;
  logic [NUM_W-1:0]        num_init;
  logic [WIDTH_BITS:0]     rem_sh;
  logic [WIDTH_BITS:0]     rem_sub;
  logic                    q_bit;
  logic [WIDTH_BITS-1:0]   rem_d;
  logic [NUM_W-1:0]        quo_d;
  logic [STEP_WIDTH-1:0]   pend_d;
  logic                    sat_d;

  assign cfg_ready  = (state_q != DIV);
  assign busy       = (state_q != IDLE);
  assign accept     = cfg_valid && cfg_ready;
  assign sof        = de_i && vs_i;
  assign scale_step = step_q;
  assign step_upd   = upd_q;
  assign err        = err_q;

  always_comb begin
    num_init = NUM_W'({cfg_in_width, {LOG2_STEP{1'b0}}});
`ifdef SCALER_STEP_CTRL_ROUND_EN
    // Half the divisor added up front turns truncation into round-to-nearest.
    num_init = num_init + NUM_W'(cfg_out_width >> 1);
`endif
  end

  always_comb begin
    rem_sh  = {rem_q, num_q[NUM_W-1]};
    rem_sub = rem_sh - {1'b0, out_w_q};
    q_bit   = (rem_sh >= {1'b0, out_w_q});
    rem_d   = q_bit ? rem_sub[WIDTH_BITS-1:0] : rem_sh[WIDTH_BITS-1:0];
    quo_d   = {quo_q[NUM_W-2:0], q_bit};
    sat_d   = 1'b0;
    pend_d  = quo_d[STEP_WIDTH-1:0];
    if (|quo_d[NUM_W-1:STEP_WIDTH]) begin
      pend_d = '1;
      sat_d  = 1'b1;
    end else if (quo_d == '0) begin
      pend_d = STEP_WIDTH'(1);
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      out_w_q <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      step_q  <= STEP_RST;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: ;
        DIV: begin
          num_q <= {num_q[NUM_W-2:0], 1'b0};
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            pend_q  <= pend_d;
            err_q   <= sat_d;
            state_q <= WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (sof) begin
            step_q  <= pend_q;
            upd_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A new config overrides the state decision above (also when SOF hits the same edge).
      if (accept) begin
        out_w_q <= cfg_out_width;
        num_q   <= num_init;
        rem_q   <= '0;
        quo_q   <= '0;
        cnt_q   <= CNT_W'(NUM_W - 1);
        err_q   <= (cfg_out_width == '0);
        state_q <= (cfg_out_width == '0) ? IDLE : DIV;
      end
    end
  end

endmodule

// File: tb/tb_scaler_step_ctrl.sv
// Bench for scaler_step_ctrl: directed test-plan scenarios plus random traffic,
// all cycles compared against a timestamp-based behavioural model.
module tb_scaler_step_ctrl;
  localparam int WB = 13;
  localparam int SW = 16;
  localparam int PIXEL_STEP = 4096;
`ifdef SCALER_STEP_CTRL_ROUND_EN
  localparam int N_DIV = 26;
  localparam int STEP_1280_1920 = 2731;
`else
  localparam int N_DIV = 25;
  localparam int STEP_1280_1920 = 2730;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [WB-1:0] cfg_in_width = '0;
  logic [WB-1:0] cfg_out_width = '0;
  logic          de_i = 1'b0;
  logic          vs_i = 1'b0;
  logic [SW-1:0] scale_step;
  logic          step_upd;
  logic          busy;
  logic          err;

  scaler_step_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_in_width(cfg_in_width), .cfg_out_width(cfg_out_width),
    .de_i(de_i), .vs_i(vs_i), .scale_step(scale_step), .step_upd(step_upd),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int t = 0;
  int n_upd = 0;
  int n_busy = 0;

  // Model: a job is accepted at edge m_t0; its result exists from edge m_t0+N_DIV
  // and may be applied by any SOF edge strictly after that.
  bit m_job = 0;
  int m_t0 = 0;
  int m_res = 0;
  bit m_res_err = 0;
  int m_step = PIXEL_STEP;
  bit m_upd = 0;
  bit m_err = 0;
  bit m_ready = 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, t);
  endtask

  function automatic void calc(input int iw, input int ow, output int res, output bit e);
    longint num;
    longint q;
    num = longint'(iw) * PIXEL_STEP;
`ifdef SCALER_STEP_CTRL_ROUND_EN
    num = num + ow / 2;
`endif
    q = num / ow;
    if (q > 65535) begin res = 65535; e = 1; end
    else if (q == 0) begin res = 1; e = 1; end
    else begin res = int'(q); e = 0; end
  endfunction

  task automatic cyc(input bit v, input int iw, input int ow, input bit de, input bit vs,
                     input bit rn);
    bit sof;
    bit pend_ok;
    @(negedge clk);
    cfg_valid = v;
    cfg_in_width = WB'(iw);
    cfg_out_width = WB'(ow);
    de_i = de;
    vs_i = vs;
    rst_n = rn;
    @(posedge clk);
    #1;
    t++;
    if (!rn) begin
      m_job = 0; m_step = PIXEL_STEP; m_upd = 0; m_err = 0; m_ready = 1;
    end else begin
      sof = de && vs;
      pend_ok = m_job && (t > m_t0 + N_DIV);
      m_upd = 0;
      if (sof && pend_ok) begin
        m_step = m_res; m_upd = 1; m_job = 0;
      end
      if (v && m_ready) begin
        if (ow == 0) begin
          m_job = 0; m_err = 1;
        end else begin
          m_job = 1; m_t0 = t; m_err = 0;
          calc(iw, ow, m_res, m_res_err);
        end
      end
      if (m_job && t == m_t0 + N_DIV) m_err = m_res_err;
      m_ready = !(m_job && t < m_t0 + N_DIV);
    end
    if (step_upd) n_upd++;
    if (busy) n_busy++;
    chk("step", int'(scale_step), m_step);
    chk("upd", int'(step_upd), int'(m_upd));
    chk("busy", int'(busy), int'(m_job));
    chk("ready", int'(cfg_ready), int'(m_ready));
    chk("err", int'(err), int'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 1);
  endtask

  task automatic sof_cyc();
    cyc(0, 0, 0, 1, 1, 1);
  endtask

  task automatic cfg(input int iw, input int ow);
    cyc(1, iw, ow, 1, 0, 1);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_step", int'(scale_step), 4096);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);

    n_upd = 0;
    sof_cyc(); idle(3); sof_cyc(); idle(2);
    chk("idle_sof_no_upd", n_upd, 0);

    n_upd = 0; n_busy = 0;
    cfg(1920, 1280); idle(29); sof_cyc();
    chk("step_1920_1280", int'(scale_step), 6144);
    chk("busy_cycles_1920_1280", n_busy, 30);
    idle(3);
    chk("upd_single_pulse", n_upd, 1);

    cfg(1280, 1920); idle(N_DIV); sof_cyc();
    chk("step_1280_1920", int'(scale_step), STEP_1280_1920);
    idle(2);

    cfg(8191, 1); idle(N_DIV);
    chk("sat_err", int'(err), 1);
    sof_cyc();
    chk("step_sat", int'(scale_step), 65535);
    idle(2);

    n_upd = 0;
    cfg(100, 0);
    chk("zero_out_err", int'(err), 1);
    chk("zero_out_busy", int'(busy), 0);
    idle(30); sof_cyc(); idle(2);
    chk("zero_out_step", int'(scale_step), 65535);
    chk("zero_out_no_upd", n_upd, 0);

    cfg(1920, 1280); idle(9); sof_cyc();
    chk("mid_div_sof", int'(scale_step), 65535);
    idle(N_DIV); sof_cyc();
    chk("post_div_sof", int'(scale_step), 6144);
    idle(2);

    n_upd = 0;
    cfg(1280, 640); idle(30); cfg(640, 1280); idle(30); sof_cyc(); idle(2);
    chk("back_to_back_step", int'(scale_step), 2048);
    chk("back_to_back_upd", n_upd, 1);

    n_upd = 0;
    cfg(1920, 1280); idle(5); cyc(0, 0, 0, 1, 0, 0);
    chk("rst_mid_div_busy", int'(busy), 0);
    idle(30); sof_cyc(); idle(2);
    chk("rst_mid_div_step", int'(scale_step), 4096);
    chk("rst_mid_div_no_upd", n_upd, 0);

    cfg(1920, 1280); idle(30);
    cyc(1, 1280, 1920, 1, 1, 1);
    chk("coinc_old_applied", int'(scale_step), 6144);
    chk("coinc_div_started", int'(cfg_ready), 0);
    idle(N_DIV); sof_cyc();
    chk("coinc_new_applied", int'(scale_step), STEP_1280_1920);

    for (int i = 0; i < 4000; i++) begin
      int iw, ow;
      bit v, de, vs, rn;
      iw = $urandom_range(0, 8191);
      ow = $urandom_range(1, 8191);
      case ($urandom_range(0, 7))
        0: ow = 0;
        1: ow = 1;
        2: begin iw = 1; ow = 8191; end
        3: ow = $urandom_range(1, 64);
        default: ;
      endcase
      v  = ($urandom_range(0, 9) == 0);
      de = ($urandom_range(0, 3) != 0);
      vs = ($urandom_range(0, 24) == 0);
      rn = ($urandom_range(0, 499) != 0);
      cyc(v, iw, ow, de, vs, rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
